odd_parity_serial_rx: RTL

Serial front end for the odd-parity checker. It receives a framed serial bit stream and de-serialises each frame into four data bits plus one parity bit, presented in parallel as a,b,c,d,p. The frame is one start bit (0), four data bits, one odd-parity bit and one stop bit (1); the idle line is high. Outputs are registered and change only when a frame completes; the downstream parity checker consumes a..d,p directly.

---
 rtl/odd_parity_serial_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/odd_parity_serial_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | odd_parity_serial_rx                                                     |
// | Deserialises start/4 data/parity/stop frames into parallel a..d,p.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module odd_parity_serial_rx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic p,
   output logic valid,
   output logic frame_err,
   output logic busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] c_CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

   localparam logic [2:0] c_S_IDLE   = 3'd0;
   localparam logic [2:0] c_S_START  = 3'd1;
   localparam logic [2:0] c_S_DATA   = 3'd2;
   localparam logic [2:0] c_S_PARITY = 3'd3;
   localparam logic [2:0] c_S_STOP   = 3'd4;
   localparam logic [2:0] c_S_WAIT   = 3'd5;

   logic          r_sync1;
   logic          r_sync2;
   logic [2:0]    r_state;
   logic [2:0]    w_state_next;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [3:0]    r_sh;
   logic          r_pb;
   logic          r_a, r_b, r_c, r_d, r_p;
   logic          r_valid;
   logic          r_ferr;

   logic w_rx_s;
   logic w_cnt_last;
   logic w_cnt_mid;
   logic w_busy;
   logic w_cnt_clr;
   logic w_smp_data;
   logic w_smp_par;
   logic w_load;

   assign w_rx_s     = r_sync2;
   assign w_cnt_last = (r_cnt == c_CNT_LAST);
   assign w_cnt_mid  = (r_cnt == c_CNT_MID);

   // Sync flops reset high so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE:   if (!w_rx_s) w_state_next = c_S_START;
         c_S_START:  if (w_cnt_mid) w_state_next = w_rx_s ? c_S_IDLE : c_S_DATA;
         c_S_DATA:   if (w_cnt_last && (r_idx == 2'd3)) w_state_next = c_S_PARITY;
         c_S_PARITY: if (w_cnt_last) w_state_next = c_S_STOP;
         c_S_STOP:   if (w_cnt_last) w_state_next = w_rx_s ? c_S_IDLE : c_S_WAIT;
         c_S_WAIT:   if (w_rx_s) w_state_next = c_S_IDLE;
         default:    w_state_next = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_busy     = (r_state != c_S_IDLE);
      w_cnt_clr  = 1'b1;
      w_smp_data = 1'b0;
      w_smp_par  = 1'b0;
      w_load     = 1'b0;
      case (r_state)
         c_S_START:  w_cnt_clr = w_cnt_mid;
         c_S_DATA: begin
            w_cnt_clr  = w_cnt_last;
            w_smp_data = w_cnt_last;
         end
         c_S_PARITY: begin
            w_cnt_clr = w_cnt_last;
            w_smp_par = w_cnt_last;
         end
         c_S_STOP: begin
            w_cnt_clr = w_cnt_last;
            w_load    = w_cnt_last;
         end
         default: w_cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_sh    <= 4'd0;
         r_pb    <= 1'b0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_c     <= 1'b0;
         r_d     <= 1'b0;
         r_p     <= 1'b0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_valid <= w_load;
         r_cnt   <= w_cnt_clr ? '0 : r_cnt + c_CNT_ONE;
         if (w_smp_data) begin
            r_sh[r_idx] <= w_rx_s;
            r_idx       <= r_idx + 2'd1;
         end else if (r_state == c_S_START) begin
            r_idx <= 2'd0;
         end
         if (w_smp_par) r_pb <= w_rx_s;
         // Data is published even on a bad stop bit; frame_err flags it.
         if (w_load) begin
            r_a    <= r_sh[0];
            r_b    <= r_sh[1];
            r_c    <= r_sh[2];
            r_d    <= r_sh[3];
            r_p    <= r_pb;
            r_ferr <= ~w_rx_s;
         end
      end
   end

   assign a         = r_a;
   assign b         = r_b;
   assign c         = r_c;
   assign d         = r_d;
   assign p         = r_p;
   assign valid     = r_valid;
   assign frame_err = r_ferr;
   assign busy      = w_busy;

endmodule
`default_nettype wire
